regfile_onehot_wr: RTL

- 8-entry x WIDTH-bit register file for the ARM datapath.
- Sits directly downstream of the 3:8 write-address decoder and consumes its one-hot output as per-register write enables.
- Provides two read ports with same-cycle write bypass.
- Enforces a hardwired zero register and flags malformed (non-one-hot) enables.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_onehot_wr_reg_word.sv | 25 ++
 rtl/regfile_onehot_wr.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and helpers for the one-hot-write register file.
//   NREG             : number of architectural registers
//   ADDR_W           : read address width
//   ZERO_REG_DEFAULT : default index of the hardwired zero register
//   is_onehot()      : 1 when exactly one enable bit is set
package regfile_pkg;

  localparam int unsigned NREG             = 8;
  localparam int unsigned ADDR_W           = 3;
  localparam int unsigned ZERO_REG_DEFAULT = 7;

  // Population count of exactly one.
  function automatic logic is_onehot(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return (n == 4'd1);
  endfunction

endpackage

// File: rtl/regfile_onehot_wr_reg_word.sv
// Single WIDTH-bit storage word with synchronous active-low clear and write enable.
//   clk, reset_n : clock, synchronous active-low clear
//   we           : write enable
//   d            : write data
//   q            : stored value
module reg_word #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flop; clear has priority over write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_onehot_wr.sv
// 8-entry register file written through a one-hot per-register enable vector.
//   clk, reset_n         : clock, synchronous active-low reset
//   wr_onehot, wr_data   : one-hot write enables (zero = idle) and write data
//   rd_addr_a/b          : read addresses
//   rd_data_a/b          : combinational read data with optional write bypass
//   onehot_err           : sticky flag, a multi-bit enable vector was seen
//   wr_count             : committed writes since reset (wraps at 16 bits)
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREG-1:0]   wr_onehot,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              onehot_err,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic             wr_valid;
  logic             wr_multi;
  logic [WIDTH-1:0] regs [NREG];

  // A write commits only for a clean one-hot vector not aimed at the zero register.
  assign wr_valid = reset_n && is_onehot(wr_onehot) && !wr_onehot[ZERO_REG];
  assign wr_multi = (|wr_onehot) && !is_onehot(wr_onehot);

  // Storage: the zero register has no flops.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_word
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_valid & wr_onehot[i]),
        .d       (wr_data),
        .q       (regs[i])
      );
    end
  end

  // Sticky error flag and committed-write counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      onehot_err <= 1'b0;
      wr_count   <= 16'd0;
    end else begin
      if (wr_multi) begin
        onehot_err <= 1'b1;
      end
      if (wr_valid) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Read muxes: stored value, then bypass of a committing write, then zero override.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if ((BYPASS != 0) && wr_valid && wr_onehot[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if ((BYPASS != 0) && wr_valid && wr_onehot[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
    if (rd_addr_a == ZERO_ADDR) begin
      rd_data_a = '0;
    end
    if (rd_addr_b == ZERO_ADDR) begin
      rd_data_b = '0;
    end
  end

endmodule
